// File: rtl/spi_conf_master_if.sv
// Handshake and SPI pin bundle for spi_conf_master.
// The master modport is the initiator's view. The slave modport is the view
// of whatever drives requests and models the serial slave.
interface spi_conf_master_if #(
    parameter int CONF_WIDTH = 48,
    parameter int ROT_WIDTH  = 16
);
    logic                  start;
    logic                  cmd_sel;
    logic [CONF_WIDTH-1:0] conf_in;
    logic                  busy;
    logic                  done;
    logic [ROT_WIDTH-1:0]  rotation_data;
    logic                  rotation_valid;
    logic                  spi_clk;
    logic                  spi_ss;
    logic                  spi_mosi;
    logic                  spi_miso;

    modport master (
        input  start, cmd_sel, conf_in, spi_miso,
        output busy, done, rotation_data, rotation_valid, spi_clk, spi_ss, spi_mosi
    );

    modport slave (
        output start, cmd_sel, conf_in, spi_miso,
        input  busy, done, rotation_data, rotation_valid, spi_clk, spi_ss, spi_mosi
    );
endinterface

// File: rtl/spi_conf_master.sv
// SPI mode-0 initiator for the config/rotation link.
// Each frame is an 8-bit command followed by one of two payloads: the 48-bit
// driver configuration, or 16 dummy bits while the 16-bit rotation word is
// read back. Frames are MSB first under a single slave select.
module spi_conf_master #(
    parameter int         CLK_DIV    = 4,
    parameter int         SS_SETUP   = 2,
    parameter int         SS_HOLD    = 2,
    parameter int         CONF_WIDTH = 48,
    parameter int         ROT_WIDTH  = 16,
    parameter logic [7:0] CMD_CONF   = 8'h01,
    parameter logic [7:0] CMD_ROT    = 8'h02
) (
    input  logic              clk_33,
    input  logic              rst,
    spi_conf_master_if.master bus
);
    // The frame register is MSB-aligned and sized for the longer payload.
    localparam int FRAME_W   = 8 + ((CONF_WIDTH > ROT_WIDTH) ? CONF_WIDTH : ROT_WIDTH);
    localparam int CONF_PAD  = FRAME_W - 8 - CONF_WIDTH;
    localparam int BIT_W     = $clog2(FRAME_W);
    localparam int CNT_MAX_A = (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
    localparam int CNT_MAX   = (CNT_MAX_A > SS_HOLD) ? CNT_MAX_A : SS_HOLD;
    localparam int CNT_W     = $clog2(CNT_MAX) + 1;

    localparam logic [BIT_W-1:0]   LAST_CONF  = BIT_W'(8 + CONF_WIDTH - 1);
    localparam logic [BIT_W-1:0]   LAST_ROT   = BIT_W'(8 + ROT_WIDTH - 1);
    localparam logic [CNT_W-1:0]   SETUP_LAST = CNT_W'(SS_SETUP - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(SS_HOLD - 1);
    localparam logic [CNT_W-1:0]   DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [FRAME_W-1:0] ROT_FRAME  = {CMD_ROT, {(FRAME_W - 8){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

    state_t               r_state, w_state;
    logic [FRAME_W-1:0]   r_shift, w_shift;
    logic [ROT_WIDTH-1:0] r_rx, w_rx;
    logic [ROT_WIDTH-1:0] r_rot_data, w_rot_data;
    logic [BIT_W-1:0]     r_bit, w_bit;
    logic [CNT_W-1:0]     r_cnt, w_cnt;
    logic                 r_is_rot, w_is_rot;
    logic                 r_sclk, w_sclk;
    logic                 r_ss, w_ss;
    logic                 r_done, w_done;
    logic                 r_valid, w_valid;
    logic [FRAME_W-1:0]   w_conf_frame;
    logic [BIT_W-1:0]     w_last_bit;

    assign w_conf_frame = FRAME_W'({CMD_CONF, bus.conf_in}) << CONF_PAD;
    assign w_last_bit   = r_is_rot ? LAST_ROT : LAST_CONF;

    // MOSI is the frame register's MSB. The register is cleared whenever
    // the link is idle, so MOSI rests low.
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.done           = r_done;
    assign bus.rotation_data  = r_rot_data;
    assign bus.rotation_valid = r_valid;
    assign bus.spi_clk        = r_sclk;
    assign bus.spi_ss         = r_ss;
    assign bus.spi_mosi       = r_shift[FRAME_W-1];

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        // NOTE: every w_ signal gets a default before the case, so no path through the case can infer a latch.
        w_state    = r_state;
        w_shift    = r_shift;
        w_rx       = r_rx;
        w_rot_data = r_rot_data;
        w_bit      = r_bit;
        w_cnt      = r_cnt;
        w_is_rot   = r_is_rot;
        w_sclk     = r_sclk;
        w_ss       = r_ss;
        w_done     = 1'b0;
        w_valid    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state  = S_SETUP;
                    w_is_rot = bus.cmd_sel;
                    w_shift  = bus.cmd_sel ? ROT_FRAME : w_conf_frame;
                    w_ss     = 1'b0;
                    w_sclk   = 1'b0;
                    w_cnt    = '0;
                    w_bit    = '0;
                end
            end
            S_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state = S_SHIFT;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt = '0;
                    if (!r_sclk) begin
                        // Rising edge: capture MISO. Command-byte bits shift out the top.
                        w_sclk = 1'b1;
                        w_rx   = ROT_WIDTH'({r_rx, bus.spi_miso});
                    end else begin
                        // Falling edge: advance MOSI, except after the last bit.
                        w_sclk = 1'b0;
                        if (r_bit == w_last_bit) begin
                            w_state = S_HOLD;
                        end else begin
                            w_bit   = r_bit + 1'b1;
                            w_shift = r_shift << 1;
                        end
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state = S_IDLE;
                    w_ss    = 1'b1;
                    w_done  = 1'b1;
                    w_shift = '0;
                    if (r_is_rot) begin
                        w_valid    = 1'b1;
                        w_rot_data = r_rx;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // State register. Reset aborts any frame at once and releases the slave.
    always_ff @(posedge clk_33 or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_rx       <= '0;
            r_rot_data <= '0;
            r_bit      <= '0;
            r_cnt      <= '0;
            r_is_rot   <= 1'b0;
            r_sclk     <= 1'b0;
            r_ss       <= 1'b1;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register load from the same pre-edge values.
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_rx       <= w_rx;
            r_rot_data <= w_rot_data;
            r_bit      <= w_bit;
            r_cnt      <= w_cnt;
            r_is_rot   <= w_is_rot;
            r_sclk     <= w_sclk;
            r_ss       <= w_ss;
            r_done     <= w_done;
            r_valid    <= w_valid;
        end
    end
endmodule

// File: tb/tb_spi_conf_master.sv
// Self-checking bench for spi_conf_master.
// Two instances are used: bus0 runs with CLK_DIV=2 and bus1 with CLK_DIV=1.
// Bus activity is observed on the pins and summarised per frame. Results are
// compared against values worked out from the frame format.
`timescale 1ns/1ps
module tb_spi_conf_master;
    localparam int CONF_W = 48;
    localparam int ROT_W  = 16;
    localparam int SETUP  = 2;
    localparam int HOLD   = 2;

    logic clk_33 = 1'b0;
    logic rst    = 1'b1;
    always #5 clk_33 = ~clk_33;

    spi_conf_master_if #(.CONF_WIDTH(CONF_W), .ROT_WIDTH(ROT_W)) bus0 ();
    spi_conf_master_if #(.CONF_WIDTH(CONF_W), .ROT_WIDTH(ROT_W)) bus1 ();

    spi_conf_master #(
        .CLK_DIV(2), .SS_SETUP(SETUP), .SS_HOLD(HOLD), .CONF_WIDTH(CONF_W),
        .ROT_WIDTH(ROT_W), .CMD_CONF(8'h01), .CMD_ROT(8'h02)
    ) dut0 (.clk_33(clk_33), .rst(rst), .bus(bus0));

    spi_conf_master #(
        .CLK_DIV(1), .SS_SETUP(SETUP), .SS_HOLD(HOLD), .CONF_WIDTH(CONF_W),
        .ROT_WIDTH(ROT_W), .CMD_CONF(8'h01), .CMD_ROT(8'h02)
    ) dut1 (.clk_33(clk_33), .rst(rst), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;

    // Slave models. Each frame answers {junk byte, rotation word}. The slave
    // presents bit k after the k-th falling spi_clk (mode 0).
    logic [23:0] s_resp0 = '0;
    logic [23:0] s_resp1 = '0;
    int          s_idx0  = 0;
    int          s_idx1  = 0;

    always @(negedge bus0.spi_clk or posedge bus0.spi_ss)
        if (bus0.spi_ss) s_idx0 = 0; else s_idx0 = s_idx0 + 1;
    always @(negedge bus1.spi_clk or posedge bus1.spi_ss)
        if (bus1.spi_ss) s_idx1 = 0; else s_idx1 = s_idx1 + 1;

    assign bus0.spi_miso = (s_idx0 < 24) ? s_resp0[5'(23 - s_idx0)] : 1'b0;
    assign bus1.spi_miso = (s_idx1 < 24) ? s_resp1[5'(23 - s_idx1)] : 1'b0;

    // Pin monitor. Per frame it records the spi_clk rises, the MOSI bits
    // seen at each rise, the slave-select low time and the high gap before
    // the frame. It also counts protocol breaches.
    logic [63:0] m_mosi_cur [2];
    logic [63:0] m_mosi_last[2];
    int m_rises_cur[2], m_rises_last[2], m_sslen_cur[2], m_sslen_last[2];
    int m_high_run[2], m_gap_last[2], m_frames[2], m_done_cnt[2], m_valid_cnt[2], m_proto_err[2];
    bit m_prev_ss[2], m_prev_sclk[2];
    logic [15:0] m_rot_exp[2];

    task automatic mon_step(input int b, input logic ss, input logic sclk, input logic mosi,
                            input logic done, input logic valid);
        if (rst) begin
            m_prev_ss[b]   = 1'b1;
            m_prev_sclk[b] = 1'b0;
            m_high_run[b]  = 0;
            return;
        end
        if (!ss) begin
            if (m_prev_ss[b]) begin
                m_gap_last[b]  = m_high_run[b];
                m_sslen_cur[b] = 0;
                m_rises_cur[b] = 0;
                m_mosi_cur[b]  = '0;
            end
            m_sslen_cur[b]++;
            if (sclk && !m_prev_sclk[b]) begin
                m_rises_cur[b]++;
                m_mosi_cur[b] = {m_mosi_cur[b][62:0], mosi};
            end
            if (done || valid) m_proto_err[b]++;
        end else begin
            if (!m_prev_ss[b]) begin
                m_sslen_last[b] = m_sslen_cur[b];
                m_rises_last[b] = m_rises_cur[b];
                m_mosi_last[b]  = m_mosi_cur[b];
                m_frames[b]++;
                m_high_run[b]   = 1;
                if (!done) m_proto_err[b]++;
            end else begin
                m_high_run[b]++;
                if (done) m_proto_err[b]++;
            end
            if (sclk || mosi) m_proto_err[b]++;
            if (done) m_done_cnt[b]++;
            if (valid) begin
                m_valid_cnt[b]++;
                if (!done) m_proto_err[b]++;
            end
        end
        m_prev_ss[b]   = ss;
        m_prev_sclk[b] = sclk;
    endtask

    always @(negedge clk_33) begin
        mon_step(0, bus0.spi_ss, bus0.spi_clk, bus0.spi_mosi, bus0.done, bus0.rotation_valid);
        mon_step(1, bus1.spi_ss, bus1.spi_clk, bus1.spi_mosi, bus1.done, bus1.rotation_valid);
    end

    // Reference model: the frame contents and timing that each request should produce.
    function automatic logic [63:0] exp_frame(input bit sel, input logic [47:0] conf);
        if (sel) return {40'h0, 8'h02, 16'h0000};
        return {8'h00, 8'h01, conf};
    endfunction

    function automatic int exp_bits(input bit sel);
        return sel ? 8 + ROT_W : 8 + CONF_W;
    endfunction

    function automatic int exp_sslen(input bit sel, input int div);
        return SETUP + exp_bits(sel) * 2 * div + HOLD;
    endfunction

    function automatic logic [47:0] rand48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic drive(input int b, input bit sel, input logic [47:0] conf);
        @(negedge clk_33);
        if (b == 0) begin
            bus0.start = 1'b1; bus0.cmd_sel = sel; bus0.conf_in = conf;
        end else begin
            bus1.start = 1'b1; bus1.cmd_sel = sel; bus1.conf_in = conf;
        end
        @(negedge clk_33);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic wait_done(input int b, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_33);
            if ((b == 0 && bus0.done === 1'b1) || (b == 1 && bus1.done === 1'b1)) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL done_timeout bus%0d: no done within %0d cycles", b, limit);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_33);
        n_checks++; if (bus0.spi_ss !== 1'b1)   begin n_fail++; $display("FAIL rst_ss: got %b want 1", bus0.spi_ss); end
        n_checks++; if (bus0.spi_clk !== 1'b0)  begin n_fail++; $display("FAIL rst_sclk: got %b want 0", bus0.spi_clk); end
        n_checks++; if (bus0.spi_mosi !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b want 0", bus0.spi_mosi); end
        n_checks++; if (bus0.busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus0.busy); end
        n_checks++; if (bus0.done !== 1'b0)     begin n_fail++; $display("FAIL rst_done: got %b want 0", bus0.done); end
        n_checks++; if (bus0.rotation_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus0.rotation_valid); end
        n_checks++; if (bus0.rotation_data !== 16'h0) begin n_fail++; $display("FAIL rst_rot: got %h want 0000", bus0.rotation_data); end
        n_checks++; if (bus1.spi_ss !== 1'b1)   begin n_fail++; $display("FAIL rst_ss1: got %b want 1", bus1.spi_ss); end
        @(negedge clk_33);
        rst = 1'b0;
        repeat (3) @(negedge clk_33);
        n_checks++; if (bus0.busy !== 1'b0 || bus0.spi_ss !== 1'b1) begin
            n_fail++; $display("FAIL post_rst_idle: busy=%b ss=%b want busy=0 ss=1", bus0.busy, bus0.spi_ss);
        end
    endtask

    task automatic test_conf_write();
        logic [47:0] words[4];
        bit ok;
        words[0] = 48'hA5A5_0F0F_1234;
        for (int i = 1; i < 4; i++) words[i] = rand48();
        for (int i = 0; i < 4; i++) begin
            int d0 = m_done_cnt[0];
            int v0 = m_valid_cnt[0];
            drive(0, 1'b0, words[i]);
            n_checks++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL conf_busy[%0d]: got %b want 1", i, bus0.busy); end
            wait_done(0, 400, ok);
            #1;
            n_checks++; if (m_rises_last[0] != exp_bits(1'b0)) begin n_fail++; $display("FAIL conf_rises[%0d]: got %0d want %0d", i, m_rises_last[0], exp_bits(1'b0)); end
            n_checks++; if (m_mosi_last[0] !== exp_frame(1'b0, words[i])) begin n_fail++; $display("FAIL conf_mosi[%0d]: got %h want %h", i, m_mosi_last[0], exp_frame(1'b0, words[i])); end
            n_checks++; if (m_sslen_last[0] != exp_sslen(1'b0, 2)) begin n_fail++; $display("FAIL conf_sslen[%0d]: got %0d want %0d", i, m_sslen_last[0], exp_sslen(1'b0, 2)); end
            n_checks++; if (m_done_cnt[0] - d0 != 1) begin n_fail++; $display("FAIL conf_done_cnt[%0d]: got %0d want 1", i, m_done_cnt[0] - d0); end
            n_checks++; if (m_valid_cnt[0] != v0) begin n_fail++; $display("FAIL conf_valid[%0d]: got %0d pulses want 0", i, m_valid_cnt[0] - v0); end
            n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL conf_busy_done[%0d]: got %b want 0", i, bus0.busy); end
            n_checks++; if (bus0.rotation_data !== m_rot_exp[0]) begin n_fail++; $display("FAIL conf_rot_kept[%0d]: got %h want %h", i, bus0.rotation_data, m_rot_exp[0]); end
        end
    endtask

    task automatic test_rot_read();
        logic [15:0] words[4];
        bit ok;
        words[0] = 16'hBEEF;
        for (int i = 1; i < 4; i++) words[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) begin
            int v0 = m_valid_cnt[0];
            int d0 = m_done_cnt[0];
            s_resp0 = {8'($urandom), words[i]};
            drive(0, 1'b1, rand48());
            wait_done(0, 200, ok);
            #1;
            n_checks++; if (bus0.rotation_valid !== 1'b1) begin n_fail++; $display("FAIL rot_valid_with_done[%0d]: got %b want 1", i, bus0.rotation_valid); end
            n_checks++; if (bus0.rotation_data !== words[i]) begin n_fail++; $display("FAIL rot_data[%0d]: got %h want %h", i, bus0.rotation_data, words[i]); end
            n_checks++; if (m_rises_last[0] != exp_bits(1'b1)) begin n_fail++; $display("FAIL rot_rises[%0d]: got %0d want %0d", i, m_rises_last[0], exp_bits(1'b1)); end
            n_checks++; if (m_mosi_last[0] !== exp_frame(1'b1, 48'h0)) begin n_fail++; $display("FAIL rot_mosi[%0d]: got %h want %h", i, m_mosi_last[0], exp_frame(1'b1, 48'h0)); end
            n_checks++; if (m_sslen_last[0] != exp_sslen(1'b1, 2)) begin n_fail++; $display("FAIL rot_sslen[%0d]: got %0d want %0d", i, m_sslen_last[0], exp_sslen(1'b1, 2)); end
            n_checks++; if (m_valid_cnt[0] - v0 != 1 || m_done_cnt[0] - d0 != 1) begin
                n_fail++; $display("FAIL rot_pulses[%0d]: valid=%0d done=%0d want 1 and 1", i, m_valid_cnt[0] - v0, m_done_cnt[0] - d0);
            end
            m_rot_exp[0] = words[i];
        end
    endtask

    task automatic test_ignore_start();
        logic [47:0] w;
        int f0;
        bit ok;
        w  = rand48();
        f0 = m_frames[0];
        drive(0, 1'b0, w);
        ok = 1'b0;
        for (int cyc = 2; cyc < 400; cyc++) begin
            @(negedge clk_33);
            if (bus0.done === 1'b1) begin ok = 1'b1; break; end
            bus0.conf_in = ~w;
            bus0.cmd_sel = 1'b1;
            bus0.start   = (cyc == 5 || cyc == 40 || cyc == 90);
        end
        bus0.start = 1'b0;
        #1;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ign_timeout: no done within 400 cycles"); end
        n_checks++; if (m_mosi_last[0] !== exp_frame(1'b0, w)) begin n_fail++; $display("FAIL ign_mosi: got %h want %h", m_mosi_last[0], exp_frame(1'b0, w)); end
        n_checks++; if (m_sslen_last[0] != exp_sslen(1'b0, 2)) begin n_fail++; $display("FAIL ign_sslen: got %0d want %0d", m_sslen_last[0], exp_sslen(1'b0, 2)); end
        n_checks++; if (bus0.rotation_data !== m_rot_exp[0]) begin n_fail++; $display("FAIL ign_rot_kept: got %h want %h", bus0.rotation_data, m_rot_exp[0]); end
        repeat (10) @(negedge clk_33);
        #1;
        n_checks++; if (bus0.busy !== 1'b0 || m_frames[0] - f0 != 1) begin
            n_fail++; $display("FAIL ign_single_frame: busy=%b frames=%0d want busy=0 frames=1", bus0.busy, m_frames[0] - f0);
        end
    endtask

    task automatic test_mid_reset();
        logic [47:0] w;
        int d0;
        bit ok;
        d0 = m_done_cnt[0];
        drive(0, 1'b0, rand48());
        repeat (84) @(negedge clk_33);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus0.spi_ss !== 1'b1)  begin n_fail++; $display("FAIL mrst_ss: got %b want 1", bus0.spi_ss); end
        n_checks++; if (bus0.spi_clk !== 1'b0) begin n_fail++; $display("FAIL mrst_sclk: got %b want 0", bus0.spi_clk); end
        n_checks++; if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin n_fail++; $display("FAIL mrst_busy_done: busy=%b done=%b want 0 0", bus0.busy, bus0.done); end
        repeat (3) @(negedge clk_33);
        rst = 1'b0;
        m_rot_exp[0] = 16'h0;
        m_rot_exp[1] = 16'h0;
        repeat (2) @(negedge clk_33);
        #1;
        n_checks++; if (m_done_cnt[0] != d0) begin n_fail++; $display("FAIL mrst_no_done: got %0d pulses want 0", m_done_cnt[0] - d0); end
        n_checks++; if (bus0.rotation_data !== 16'h0) begin n_fail++; $display("FAIL mrst_rot: got %h want 0000", bus0.rotation_data); end
        w = rand48();
        drive(0, 1'b0, w);
        wait_done(0, 400, ok);
        #1;
        n_checks++; if (m_mosi_last[0] !== exp_frame(1'b0, w)) begin n_fail++; $display("FAIL mrst_next_mosi: got %h want %h", m_mosi_last[0], exp_frame(1'b0, w)); end
        n_checks++; if (m_rises_last[0] != exp_bits(1'b0) || m_sslen_last[0] != exp_sslen(1'b0, 2)) begin
            n_fail++; $display("FAIL mrst_next_timing: rises=%0d sslen=%0d want %0d %0d", m_rises_last[0], m_sslen_last[0], exp_bits(1'b0), exp_sslen(1'b0, 2));
        end
    endtask

    task automatic test_back_to_back();
        bit          sel, cur_sel;
        logic [47:0] conf, cur_conf;
        logic [15:0] word, cur_word;
        int f0;
        bit ok;
        f0   = m_frames[0];
        sel  = 1'($urandom);
        conf = rand48();
        word = 16'($urandom);
        @(negedge clk_33);
        s_resp0 = {8'($urandom), word};
        bus0.cmd_sel = sel; bus0.conf_in = conf; bus0.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cur_sel = sel; cur_conf = conf; cur_word = word;
            wait_done(0, 400, ok);
            if (k < 3) begin
                sel  = ~cur_sel;
                conf = rand48();
                word = 16'($urandom);
                s_resp0 = {8'($urandom), word};
                bus0.cmd_sel = sel; bus0.conf_in = conf;
            end else begin
                bus0.start = 1'b0;
            end
            #1;
            n_checks++; if (m_mosi_last[0] !== exp_frame(cur_sel, cur_conf)) begin n_fail++; $display("FAIL b2b_mosi[%0d]: got %h want %h", k, m_mosi_last[0], exp_frame(cur_sel, cur_conf)); end
            n_checks++; if (m_sslen_last[0] != exp_sslen(cur_sel, 2)) begin n_fail++; $display("FAIL b2b_sslen[%0d]: got %0d want %0d", k, m_sslen_last[0], exp_sslen(cur_sel, 2)); end
            if (k > 0) begin
                n_checks++; if (m_gap_last[0] != 1) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d want 1", k, m_gap_last[0]); end
            end
            if (cur_sel) begin
                n_checks++; if (bus0.rotation_data !== cur_word) begin n_fail++; $display("FAIL b2b_rot[%0d]: got %h want %h", k, bus0.rotation_data, cur_word); end
            end
        end
        repeat (6) @(negedge clk_33);
        #1;
        n_checks++; if (bus0.busy !== 1'b0 || m_frames[0] - f0 != 4) begin
            n_fail++; $display("FAIL b2b_frames: busy=%b frames=%0d want busy=0 frames=4", bus0.busy, m_frames[0] - f0);
        end
    endtask

    task automatic test_clk_div1();
        logic [15:0] words[2];
        bit ok;
        words[0] = 16'h8001;
        words[1] = 16'($urandom);
        for (int i = 0; i < 2; i++) begin
            s_resp1 = {8'($urandom), words[i]};
            drive(1, 1'b1, rand48());
            wait_done(1, 200, ok);
            #1;
            n_checks++; if (bus1.rotation_data !== words[i] || bus1.rotation_valid !== 1'b1) begin
                n_fail++; $display("FAIL div1_rot[%0d]: got %h valid=%b want %h valid=1", i, bus1.rotation_data, bus1.rotation_valid, words[i]);
            end
            n_checks++; if (m_rises_last[1] != exp_bits(1'b1)) begin n_fail++; $display("FAIL div1_rises[%0d]: got %0d want %0d", i, m_rises_last[1], exp_bits(1'b1)); end
            n_checks++; if (m_sslen_last[1] != exp_sslen(1'b1, 1)) begin n_fail++; $display("FAIL div1_sslen[%0d]: got %0d want %0d", i, m_sslen_last[1], exp_sslen(1'b1, 1)); end
            n_checks++; if (m_mosi_last[1] !== exp_frame(1'b1, 48'h0)) begin n_fail++; $display("FAIL div1_mosi[%0d]: got %h want %h", i, m_mosi_last[1], exp_frame(1'b1, 48'h0)); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.start = 1'b0; bus0.cmd_sel = 1'b0; bus0.conf_in = '0;
        bus1.start = 1'b0; bus1.cmd_sel = 1'b0; bus1.conf_in = '0;
        m_rot_exp[0] = 16'h0;
        m_rot_exp[1] = 16'h0;
        test_reset();
        test_conf_write();
        test_rot_read();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_clk_div1();
        repeat (4) @(negedge clk_33);
        for (int b = 0; b < 2; b++) begin
            n_checks++;
            if (m_proto_err[b] != 0) begin n_fail++; $display("FAIL protocol bus%0d: got %0d breaches want 0", b, m_proto_err[b]); end
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
